tin_psum_collector: RTL and testbench
=====================================

// Module: tin_psum_collector
// PURPOSE
//  Receive end of the Tin adder-tree output. The tree has no valid and no stall, so this block re-times
//  valid/first/last tags through a delay line matched to the tree latency. It accumulates tree sums over
//  the CH_in/Tin slices of one output pixel. Completed partial sums go into a small FIFO that drives the
//  downstream bias/activation stage over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  32  width of one Tin lane product fed to the tree
//  LOG2TIN     6   log2(base_Tin); tree output width IN_W = DATA_WIDTH+LOG2TIN
//  TREE_LAT    6   cycles from beat launch at the tree input to the tree sum (6 for base_Tin=64)
//  ACC_W       48  accumulator / o_psum width, signed, must be >= IN_W
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >= 2
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  i_vld       in   1      beat launched into the tree this cycle
//  i_first     in   1      beat is the first slice of a group (qualified by i_vld)
//  i_last      in   1      beat is the last slice of a group (qualified by i_vld)
//  i_tree_dat  in   IN_W   tree output, signed, sampled TREE_LAT cycles after launch
//  o_stall     out  1      upstream must not launch an i_last beat while high
//  o_psum      out  ACC_W  head-of-FIFO partial sum, signed
//  o_vld       out  1      o_psum valid
//  i_rdy       in   1      downstream accepts; pop occurs when o_vld & i_rdy
//  o_seq_err   out  1      sticky: first/last protocol violation
//  o_ovf_err   out  1      sticky: push into a full FIFO; the result is dropped
//  o_sat       out  1      sticky: saturation occurred (tied 0 without PSUM_SAT_EN)
// BEHAVIOUR
//  - Reset: delay line, acc, FIFO pointers and count cleared. All outputs 0; FSM goes to IDLE.
//  - Reset mid-group discards the group and every in-flight beat.
//  - Delay line: TREE_LAT stages of {vld,first,last}. Tap t_* lines up with i_tree_dat.
//  - sx = sign-extension of i_tree_dat to ACC_W.
//  - FSM IDLE:
//    - t_vld&t_first&t_last: push sx; stay IDLE.
//    - t_vld&t_first: acc<=sx; go to ACCUM.
//    - t_vld&!t_first: set seq_err, ignore the beat.
//  - FSM ACCUM (t_vld beats; no t_vld = hold):
//    - !t_first&!t_last: acc<=acc+sx.
//    - !t_first&t_last: push acc+sx; go to IDLE.
//    - t_first: set seq_err; restart the group as in IDLE (acc<=sx, or push sx if t_last also set).
//  - Arithmetic: signed two's complement; without the macro, wraps at ACC_W.
//  - Latency: beat launched at cycle N; tree sum and push at cycle N+TREE_LAT.
//    With the FIFO empty, o_vld rises at N+TREE_LAT+1.
//  - FIFO: first-in first-out; o_psum and o_vld are registered from the head entry.
//    - Push and pop in the same cycle are legal when full; count is unchanged.
//    - Pop when empty: no effect.
//    - Push when full without a pop: entry dropped, ovf_err set.
//  - o_stall = (fifo_count + last-tagged beats in the delay line) >= FIFO_DEPTH, combinational.
//  - Error flags are sticky and cleared only by rst.
// CONFIGURATION
//  PSUM_SAT_EN defined:
//    - every acc update and push value clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
//    - o_sat is set sticky on any clamp.
//  PSUM_SAT_EN undefined: wrap-around arithmetic; o_sat constant 0; no clamp logic.
// TESTING
//  1 Single beat: first=last=1, tree=-5 -> o_vld at N+TREE_LAT+1, o_psum=-5 sign-extended, one pop.
//  2 Group of 4: 100,-30,7,1000 launched back-to-back -> exactly one output, o_psum=1077.
//  3 Backpressure: i_rdy=0, launch 6 single-beat groups obeying o_stall (FIFO_DEPTH=4).
//    -> o_stall high after the 4th launch; groups 5-6 are held off.
//    -> raising i_rdy drains 1..6 in order; no ovf_err.
//  4 Overflow: ignore o_stall, 5 lasts with i_rdy=0 -> o_ovf_err=1, 5th dropped, entries 1-4 intact.
//  5 Protocol: beat with first=0 in IDLE -> o_seq_err=1, no output.
//    first mid-group -> restart; output = new group only.
//  6 Saturation, ACC_W=40, repeated 2^37 beats x5:
//    -> with PSUM_SAT_EN: o_psum=2^39-1, o_sat=1;
//    -> without: wrapped value 5*2^37-2^40, o_sat=0.

Source files
------------

// File: rtl/tin_psum_collector.sv
// tin_psum_collector: receive end of the Tin adder tree.
// Re-times valid/first/last through a delay line matched to the tree latency,
// accumulates tree sums across the slices of one output pixel and queues each
// completed partial sum in a small FIFO with a valid/ready output.
// Optional feature macro: PSUM_SAT_EN (saturating accumulate, sticky o_sat).
module tin_psum_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2TIN    = 6,
  parameter int unsigned TREE_LAT   = 6,
  parameter int unsigned ACC_W      = 48,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_vld,
  input  logic                                 i_first,
  input  logic                                 i_last,
  input  logic signed [DATA_WIDTH+LOG2TIN-1:0] i_tree_dat,
  output logic                                 o_stall,
  output logic signed [ACC_W-1:0]              o_psum,
  output logic                                 o_vld,
  input  logic                                 i_rdy,
  output logic                                 o_seq_err,
  output logic                                 o_ovf_err,
  output logic                                 o_sat
);

  localparam int unsigned IN_W   = DATA_WIDTH + LOG2TIN;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LCNT_W = $clog2(TREE_LAT + FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Delay line of beat tags; the last stage is aligned with i_tree_dat
  logic [TREE_LAT-1:0] dl_vld;
  logic [TREE_LAT-1:0] dl_first;
  logic [TREE_LAT-1:0] dl_last;
  logic                t_vld;
  logic                t_first;
  logic                t_last;

  logic [0:0]              state;
  logic [0:0]              state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] sum;
  logic                    push;
  logic signed [ACC_W-1:0] push_val;
  logic                    seq_set;

  logic signed [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_nxt;
  logic [PTR_W-1:0]        wr_nxt;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_nxt;
  logic                    pop;
  logic                    push_ok;
  logic                    ovf_set;
  logic signed [ACC_W-1:0] head_nxt;
  logic [LCNT_W-1:0]       lcnt;

  // Shift the tags one stage per cycle; reset flushes every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld   <= '0;
      dl_first <= '0;
      dl_last  <= '0;
    end else begin
      dl_vld[0]   <= i_vld;
      dl_first[0] <= i_first;
      dl_last[0]  <= i_last;
      for (int k = 1; k < TREE_LAT; k++) begin
        dl_vld[k]   <= dl_vld[k-1];
        dl_first[k] <= dl_first[k-1];
        dl_last[k]  <= dl_last[k-1];
      end
    end
  end

  assign t_vld   = dl_vld[TREE_LAT-1];
  assign t_first = dl_first[TREE_LAT-1];
  assign t_last  = dl_last[TREE_LAT-1];
  assign sx      = ACC_W'(i_tree_dat);

`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_w;
  logic                  sum_ovf;
  logic                  sat_set;

  // Widened add, clamped to the signed accumulator range
  always_comb begin
    sum_w   = (ACC_W+1)'(acc) + (ACC_W+1)'(sx);
    sum_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    if (sum_ovf) sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    else         sum = sum_w[ACC_W-1:0];
  end
`else
  assign sum = acc + sx;
`endif

  // Group FSM: next state, accumulator update and push request
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    push      = 1'b0;
    push_val  = sx;
    seq_set   = 1'b0;
`ifdef PSUM_SAT_EN
    sat_set   = 1'b0;
`endif
    if (t_vld) begin
      if (t_first) begin
        // A first tag always (re)starts a group; mid-group it is a protocol error
        seq_set = (state == ST_ACCUM);
        if (t_last) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          acc_nxt   = sx;
          state_nxt = ST_ACCUM;
        end
      end else if (state == ST_IDLE) begin
        seq_set = 1'b1;
      end else begin
`ifdef PSUM_SAT_EN
        sat_set = sum_ovf;
`endif
        if (t_last) begin
          push      = 1'b1;
          push_val  = sum;
          state_nxt = ST_IDLE;
        end else begin
          acc_nxt = sum;
        end
      end
    end
  end

  // FSM state and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
    end
  end

  // FIFO pointer/count arithmetic and next head value (bypass when written into empty)
  always_comb begin
    pop       = o_vld & i_rdy;
    push_ok   = push & ((count != CNT_W'(FIFO_DEPTH)) | pop);
    ovf_set   = push & ~push_ok;
    count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
    rd_nxt    = rd_ptr + PTR_W'(pop);
    wr_nxt    = wr_ptr + PTR_W'(push_ok);
    if (push_ok && ((count - CNT_W'(pop)) == '0)) head_nxt = push_val;
    else                                          head_nxt = mem[rd_nxt];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_val;
  end

  // FIFO control and registered head outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      o_vld  <= 1'b0;
      o_psum <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= count_nxt;
      o_vld  <= (count_nxt != '0);
      o_psum <= (count_nxt != '0) ? head_nxt : '0;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      o_seq_err <= 1'b0;
      o_ovf_err <= 1'b0;
    end else begin
      o_seq_err <= o_seq_err | seq_set;
      o_ovf_err <= o_ovf_err | ovf_set;
    end
  end

`ifdef PSUM_SAT_EN
  // Sticky saturation flag
  always_ff @(posedge clk) begin
    if (rst) o_sat <= 1'b0;
    else     o_sat <= o_sat | sat_set;
  end
`else
  assign o_sat = 1'b0;
`endif

  // Stall when queued results plus results still in the tree could fill the FIFO
  always_comb begin
    lcnt = LCNT_W'(count);
    for (int k = 0; k < TREE_LAT; k++) begin
      lcnt = lcnt + LCNT_W'(dl_vld[k] & dl_last[k]);
    end
    o_stall = (lcnt >= LCNT_W'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_tin_psum_collector.sv
// Directed bench for tin_psum_collector: default instance plus a 40-bit
// accumulator instance for the wrap/saturation case (PSUM_SAT_EN aware).
module tb_tin_psum_collector;

  localparam int unsigned LAT = 6;

  logic   clk = 1'b0;
  logic   rst;
  logic   vld;
  logic   first;
  logic   last;
  logic   rdy;
  longint beat_dat;
  longint pipe [LAT];

  logic signed [37:0] m_tree;
  logic               m_stall;
  logic signed [47:0] m_psum;
  logic               m_vld;
  logic               m_seq;
  logic               m_ovf;
  logic               m_sat;

  logic signed [38:0] s_tree;
  logic               s_stall;
  logic signed [39:0] s_psum;
  logic               s_vld;
  logic               s_seq;
  logic               s_ovf;
  logic               s_sat;

  int     n_chk = 0;
  int     n_fail = 0;
  longint got_q [$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the adder tree: fixed latency, no stall
  always @(posedge clk) begin
    pipe[0] <= beat_dat;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign m_tree = 38'(pipe[LAT-1]);
  assign s_tree = 39'(pipe[LAT-1]);

  tin_psum_collector u_dut (
    .clk(clk), .rst(rst), .i_vld(vld), .i_first(first), .i_last(last),
    .i_tree_dat(m_tree), .o_stall(m_stall), .o_psum(m_psum), .o_vld(m_vld),
    .i_rdy(rdy), .o_seq_err(m_seq), .o_ovf_err(m_ovf), .o_sat(m_sat)
  );

  tin_psum_collector #(.DATA_WIDTH(33), .ACC_W(40)) u_sat (
    .clk(clk), .rst(rst), .i_vld(vld), .i_first(first), .i_last(last),
    .i_tree_dat(s_tree), .o_stall(s_stall), .o_psum(s_psum), .o_vld(s_vld),
    .i_rdy(rdy), .o_seq_err(s_seq), .o_ovf_err(s_ovf), .o_sat(s_sat)
  );

  // Collect every accepted output of the default instance
  always @(negedge clk) begin
    if (!rst && m_vld && rdy) got_q.push_back(longint'(m_psum));
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input longint d);
    vld = v; first = f; last = l; beat_dat = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; first = 1'b0; last = 1'b0; beat_dat = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Launch a single-beat group once o_stall allows it (bounded wait)
  task automatic launch_obey(input string tag, input longint d);
    int w = 0;
    while (m_stall && w < 200) begin
      idle(1);
      w++;
    end
    check(tag, longint'(m_stall), 0);
    drive(1'b1, 1'b1, 1'b1, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit     found;
    longint p37;
    longint exp_s;
    rdy = 1'b1;
    do_reset();

    // Reset state
    check("rst_vld",   longint'(m_vld), 0);
    check("rst_psum",  longint'(m_psum), 0);
    check("rst_stall", longint'(m_stall), 0);
    check("rst_seq",   longint'(m_seq), 0);
    check("rst_ovf",   longint'(m_ovf), 0);
    check("rst_sat",   longint'(m_sat), 0);

    // 1: single beat, latency TREE_LAT+1, one pop
    drive(1'b1, 1'b1, 1'b1, -5);
    idle(5);
    check("t1_vld_early", longint'(m_vld), 0);
    idle(1);
    check("t1_vld",  longint'(m_vld), 1);
    check("t1_psum", longint'(m_psum), -5);
    check("t1_psum_bits", longint'({16'd0, m_psum}), 64'h0000_FFFF_FFFF_FFFB);
    idle(1);
    check("t1_popped", longint'(m_vld), 0);
    check("t1_count", longint'(got_q.size()), 1);

    // 2: group of four back-to-back beats
    got_q.delete();
    drive(1'b1, 1'b1, 1'b0, 100);
    drive(1'b1, 1'b0, 1'b0, -30);
    drive(1'b1, 1'b0, 1'b0, 7);
    drive(1'b1, 1'b0, 1'b1, 1000);
    idle(12);
    check("t2_count", longint'(got_q.size()), 1);
    if (got_q.size() > 0) check("t2_psum", got_q[0], 1077);

    // 3: backpressure obeying o_stall
    got_q.delete();
    rdy = 1'b0;
    for (int g = 0; g < 4; g++) launch_obey("t3_stall_low", 11 + g);
    check("t3_stall_after4", longint'(m_stall), 1);
    idle(10);
    check("t3_stall_held", longint'(m_stall), 1);
    check("t3_head_vld",   longint'(m_vld), 1);
    check("t3_head_psum",  longint'(m_psum), 11);
    check("t3_no_pop",     longint'(got_q.size()), 0);
    rdy = 1'b1;
    launch_obey("t3_stall_wait5", 15);
    launch_obey("t3_stall_wait6", 16);
    idle(20);
    check("t3_count", longint'(got_q.size()), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check($sformatf("t3_order%0d", i), got_q[i], 11 + i);
    check("t3_ovf", longint'(m_ovf), 0);

    // 4: overflow ignoring o_stall
    do_reset();
    got_q.delete();
    rdy = 1'b0;
    for (int g = 0; g < 5; g++) drive(1'b1, 1'b1, 1'b1, 21 + g);
    idle(10);
    check("t4_ovf",  longint'(m_ovf), 1);
    check("t4_head", longint'(m_psum), 21);
    rdy = 1'b1;
    idle(10);
    check("t4_count", longint'(got_q.size()), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check($sformatf("t4_entry%0d", i), got_q[i], 21 + i);

    // 5: protocol violations
    do_reset();
    got_q.delete();
    check("t5_seq_clear", longint'(m_seq), 0);
    drive(1'b1, 1'b0, 1'b1, 9);
    idle(10);
    check("t5_seq_idle",  longint'(m_seq), 1);
    check("t5_no_output", longint'(got_q.size()), 0);
    drive(1'b1, 1'b1, 1'b0, 50);
    drive(1'b1, 1'b0, 1'b0, 60);
    drive(1'b1, 1'b1, 1'b0, 5);
    drive(1'b1, 1'b0, 1'b1, 6);
    idle(12);
    check("t5_restart_count", longint'(got_q.size()), 1);
    if (got_q.size() > 0) check("t5_restart_psum", got_q[0], 11);

    // 6: 40-bit accumulator, five beats of 2^37
    do_reset();
    p37 = longint'(1) << 37;
    drive(1'b1, 1'b1, 1'b0, p37);
    drive(1'b1, 1'b0, 1'b0, p37);
    drive(1'b1, 1'b0, 1'b0, p37);
    drive(1'b1, 1'b0, 1'b0, p37);
    drive(1'b1, 1'b0, 1'b1, p37);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      if (s_vld) found = 1'b1;
      else idle(1);
    end
    check("t6_vld_seen", longint'(found), 1);
`ifdef PSUM_SAT_EN
    exp_s = (longint'(1) << 39) - 1;
    check("t6_psum", longint'(s_psum), exp_s);
    check("t6_sat",  longint'(s_sat), 1);
`else
    exp_s = -3 * p37;
    check("t6_psum", longint'(s_psum), exp_s);
    check("t6_sat",  longint'(s_sat), 0);
`endif
    check("t6_seq",   longint'(s_seq), 0);
    check("t6_ovf",   longint'(s_ovf), 0);
    idle(4);
    check("t6_stall", longint'(s_stall), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
